// File: rtl/uart_mvm_tile.sv
// UART-fed signed 4x4 matrix-vector multiplier tile: receives a 6-byte {K,X} frame,
// computes Y = K*X and returns the 40-bit sign-extended result as 5 UART bytes.
module uart_mvm_tile #(
   parameter int unsigned R                = 4,
   parameter int unsigned C                = 4,
   parameter int unsigned W_X              = 4,
   parameter int unsigned W_K              = 2,
   parameter int unsigned W_Y_OUT          = 10,
   parameter int unsigned CLOCKS_PER_PULSE = 4,
   parameter int unsigned BITS_PER_WORD    = 8,
   parameter int unsigned PACKET_SIZE_TX   = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int unsigned W_Y         = W_X + W_K + $clog2(C);
   localparam int unsigned KX_W        = C * W_X + R * C * W_K;
   localparam int unsigned FRAME_BYTES = KX_W / BITS_PER_WORD;
   localparam int unsigned Y_W         = R * W_Y_OUT;
   localparam int unsigned TX_BYTES    = Y_W / BITS_PER_WORD;
   localparam int unsigned CNT_W       = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
   localparam int unsigned RXB_W       = $clog2(BITS_PER_WORD);
   localparam int unsigned FB_W        = $clog2(FRAME_BYTES);
   localparam int unsigned TXBIT_W     = $clog2(PACKET_SIZE_TX);
   localparam int unsigned TXB_W       = $clog2(TX_BYTES);

   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(CLOCKS_PER_PULSE - 1);
   localparam logic [CNT_W-1:0]   CNT_HALF   = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [RXB_W-1:0]   RXB_LAST   = RXB_W'(BITS_PER_WORD - 1);
   localparam logic [FB_W-1:0]    FB_LAST    = FB_W'(FRAME_BYTES - 1);
   localparam logic [TXBIT_W-1:0] TXBIT_LAST = TXBIT_W'(PACKET_SIZE_TX - 1);
   localparam logic [TXB_W-1:0]   TXB_LAST   = TXB_W'(TX_BYTES - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

   // ---------------- RX ----------------
   rx_state_t                  rx_state, rx_state_n;
   logic                       rx_meta, rx_sync;
   logic [CNT_W-1:0]           rx_cnt;
   logic [RXB_W-1:0]           rx_bit;
   logic [BITS_PER_WORD-2:0]   rx_shift;
   logic [BITS_PER_WORD-1:0]   rx_byte;
   logic [FB_W-1:0]            rx_byte_cnt;
   logic [KX_W-1:0]            frame;
   logic                       frame_done;
   logic                       rx_half, rx_full, rx_sample, rx_accept;

   always_comb begin
      rx_half    = (rx_cnt == CNT_HALF);
      rx_full    = (rx_cnt == CNT_MAX);
      rx_sample  = (rx_state == RX_DATA) && rx_full;
      rx_byte    = {rx_sync, rx_shift};
      rx_state_n = rx_state;
      rx_accept  = 1'b0;
      case (rx_state)
         RX_IDLE:  if (!rx_sync) rx_state_n = RX_START;
         RX_START: if (rx_half) rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_full && rx_bit == RXB_LAST) begin
                      rx_state_n = RX_STOP;
                      rx_accept  = 1'b1;
                   end
         RX_STOP:  if (rx_full) rx_state_n = RX_IDLE;
         default:  rx_state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) rx_state <= RX_IDLE;
      else     rx_state <= rx_state_n;
   end

   // The byte is committed as its last data bit is sampled, so the stop bit
   // period overlaps the compute and TX start-up latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta     <= 1'b1;
         rx_sync     <= 1'b1;
         rx_cnt      <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rx_byte_cnt <= '0;
         frame       <= '0;
         frame_done  <= 1'b0;
      end else begin
         rx_meta <= ui_in[0];
         rx_sync <= rx_meta;
         if (rx_state_n != rx_state || rx_full) rx_cnt <= '0;
         else                                   rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_START) rx_bit <= '0;
         else if (rx_sample)       rx_bit <= rx_bit + 1'b1;
         if (rx_sample) rx_shift <= {rx_sync, rx_shift[BITS_PER_WORD-2:1]};
         for (int unsigned n = 0; n < FRAME_BYTES; n++) begin
            if (rx_accept && rx_byte_cnt == FB_W'(n))
               frame[BITS_PER_WORD*n +: BITS_PER_WORD] <= rx_byte;
         end
         if (rx_accept) rx_byte_cnt <= (rx_byte_cnt == FB_LAST) ? '0 : rx_byte_cnt + 1'b1;
         frame_done <= rx_accept && (rx_byte_cnt == FB_LAST);
      end
   end

   // ---------------- MVM ----------------
   // Sign-extended operands multiplied modulo 2^W_Y give the exact signed result.
   logic [Y_W-1:0] ybus;
   logic [W_Y-1:0] acc, xv, kv;

   always_comb begin
      ybus = '0;
      acc  = '0;
      xv   = '0;
      kv   = '0;
      for (int unsigned r = 0; r < R; r++) begin
         acc = '0;
         for (int unsigned c = 0; c < C; c++) begin
            xv  = {{(W_Y-W_X){frame[W_X*c + W_X - 1]}}, frame[W_X*c +: W_X]};
            kv  = {{(W_Y-W_K){frame[C*W_X + C*W_K*r + W_K*c + W_K - 1]}},
                   frame[C*W_X + C*W_K*r + W_K*c +: W_K]};
            acc = acc + kv * xv;
         end
         ybus[W_Y_OUT*r +: W_Y_OUT] = {{(W_Y_OUT-W_Y){acc[W_Y-1]}}, acc};
      end
   end

   // ---------------- Result buffer + TX ----------------
   tx_state_t             tx_state, tx_state_n;
   logic [Y_W-1:0]        pend, tx_word;
   logic                  pend_valid;
   logic [CNT_W-1:0]      tx_cnt;
   logic [TXBIT_W-1:0]    tx_bit;
   logic [TXB_W-1:0]      tx_byte;
   logic [PACKET_SIZE_TX-1:0] tx_pkt;
   logic                  tx_load, tx_bit_end, tx_byte_end;

   function automatic logic [PACKET_SIZE_TX-1:0] packet(input logic [BITS_PER_WORD-1:0] b);
      return {{(PACKET_SIZE_TX-BITS_PER_WORD-1){1'b1}}, b, 1'b0};
   endfunction

   always_comb begin
      tx_bit_end  = (tx_cnt == CNT_MAX);
      tx_byte_end = tx_bit_end && (tx_bit == TXBIT_LAST);
      tx_state_n  = tx_state;
      tx_load     = 1'b0;
      case (tx_state)
         TX_IDLE: if (pend_valid) begin
                     tx_load    = 1'b1;
                     tx_state_n = TX_SEND;
                  end
         TX_SEND: if (tx_byte_end && tx_byte == TXB_LAST) tx_state_n = TX_IDLE;
         default: tx_state_n = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) tx_state <= TX_IDLE;
      else     tx_state <= tx_state_n;
   end

   // A new frame always lands in pend; if TX grabs the old entry that same cycle it is not lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend       <= '0;
         pend_valid <= 1'b0;
         tx_word    <= '0;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_byte    <= '0;
         tx_pkt     <= '1;
      end else begin
         if (frame_done) begin
            pend       <= ybus;
            pend_valid <= 1'b1;
         end else if (tx_load) begin
            pend_valid <= 1'b0;
         end
         if (tx_load) begin
            tx_pkt  <= packet(pend[BITS_PER_WORD-1:0]);
            tx_word <= pend >> BITS_PER_WORD;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_byte <= '0;
         end else if (tx_state == TX_SEND) begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            if (tx_byte_end) begin
               tx_bit  <= '0;
               tx_byte <= tx_byte + 1'b1;
               tx_word <= tx_word >> BITS_PER_WORD;
               tx_pkt  <= (tx_byte == TXB_LAST) ? '1 : packet(tx_word[BITS_PER_WORD-1:0]);
            end else if (tx_bit_end) begin
               tx_bit <= tx_bit + 1'b1;
               tx_pkt <= {1'b1, tx_pkt[PACKET_SIZE_TX-1:1]};
            end
         end
      end
   end

   assign uo_out  = {7'b0, tx_pkt[0]};
   assign uio_out = '0;
   assign uio_oe  = '0;

   logic unused_ok;
   assign unused_ok = &{1'b0, ena, ui_in[7:1], uio_in};

endmodule

// File: tb/tb_uart_mvm_tile.sv
// Self-checking bench for uart_mvm_tile: directed vector table, randomized frames
// against an arithmetic MVM model, and a reset-mid-frame sequence.
module tb_uart_mvm_tile;

   localparam int CPP = 4;

   typedef logic [7:0] frame_t [6];
   typedef logic [7:0] resp_t  [5];
   typedef struct {
      frame_t rx;
      resp_t  tx;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, ena;
   logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

   int          tests = 0;
   int          fails = 0;
   int unsigned cyc = 0;
   int unsigned last_stop_cyc = 0;
   logic [7:0]  txq[$];
   int unsigned tstart[$];
   logic [7:0]  expq[$];
   vec_t        vecs[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_mvm_tile dut (
      .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: decode fields from the byte stream with integer arithmetic.
   function automatic void mvm_model(input frame_t f, output resp_t r);
      int x[4];
      int v, k, y;
      longint unsigned yb = 0;
      for (int c = 0; c < 4; c++) begin
         v = (int'(f[c/2]) >> (4*(c%2))) & 15;
         x[c] = (v >= 8) ? v - 16 : v;
      end
      for (int row = 0; row < 4; row++) begin
         y = 0;
         for (int c = 0; c < 4; c++) begin
            v = (int'(f[2+row]) >> (2*c)) & 3;
            k = (v >= 2) ? v - 4 : v;
            y += k * x[c];
         end
         yb |= longint'(y & 1023) << (10*row);
      end
      for (int n = 0; n < 5; n++) r[n] = 8'((yb >> (8*n)) & 255);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk); ui_in[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (CPP) @(negedge clk);
         ui_in[0] = b[i];
      end
      repeat (CPP) @(negedge clk);
      ui_in[0] = 1'b1;
      last_stop_cyc = cyc;
      repeat (CPP) @(negedge clk);
   endtask

   task automatic send_frame(input frame_t f, input bit gaps);
      for (int i = 0; i < 6; i++) begin
         send_byte(f[i]);
         if (gaps) repeat ($urandom_range(1, 20)) @(negedge clk);
      end
   endtask

   task automatic wait_bytes(input int n, input int budget, input string name, output bit ok);
      int i = 0;
      while (txq.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      ok = (txq.size() >= n);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s timeout: got %0d bytes, expected %0d", name, txq.size(), n);
      end
   endtask

   // TX line decoder: samples each of the 13 bit periods at mid-bit.
   initial begin : tx_monitor
      logic [12:0] bits;
      int unsigned t;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && uo_out[0] === 1'b0) begin
            t = cyc;
            @(negedge clk);
            bits[0] = uo_out[0];
            for (int k = 1; k < 13; k++) begin
               repeat (CPP) @(negedge clk);
               bits[k] = uo_out[0];
            end
            check("tx_framing", {bits[12:9], bits[0]}, 5'b11110);
            txq.push_back(bits[8:1]);
            tstart.push_back(t);
         end
      end
   end

   initial begin : main
      bit    ok;
      frame_t fr;
      resp_t  rs;

      rst = 1'b1; ena = 1'b1; ui_in = 8'h01; uio_in = 8'h00;
      vecs[0].rx = '{8'h11, 8'h11, 8'h55, 8'h55, 8'h55, 8'h55};
      vecs[0].tx = '{8'h04, 8'h10, 8'h40, 8'h00, 8'h01};
      vecs[1].rx = '{8'h88, 8'h88, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
      vecs[1].tx = '{8'h40, 8'h00, 8'h01, 8'h04, 8'h10};
      vecs[2].rx = '{8'hFF, 8'hFF, 8'h55, 8'h55, 8'h55, 8'h55};
      vecs[2].tx = '{8'hFC, 8'hF3, 8'hCF, 8'h3F, 8'hFF};

      repeat (2) @(posedge clk);
      #1;
      check("reset_uo_out", uo_out, 8'h01);
      check("reset_uio_oe", uio_oe, 8'h00);
      check("reset_uio_out", uio_out, 8'h00);
      @(negedge clk); rst = 1'b0;
      repeat (50) @(negedge clk);
      check("idle_no_tx", txq.size(), 0);
      check("idle_line", uo_out, 8'h01);

      for (int v = 0; v < 3; v++) begin
         txq.delete(); tstart.delete();
         send_frame(vecs[v].rx, 1'b0);
         wait_bytes(5, 700, $sformatf("vec%0d", v), ok);
         if (ok) begin
            for (int i = 0; i < 5; i++)
               check($sformatf("vec%0d_byte%0d", v, i), txq[i], vecs[v].tx[i]);
            for (int i = 1; i < 5; i++)
               check($sformatf("vec%0d_spacing%0d", v, i), tstart[i] - tstart[i-1], 52);
            check($sformatf("vec%0d_latency_ok", v), (tstart[0] - last_stop_cyc) <= 5, 1);
         end
         repeat (80) @(negedge clk);
         check($sformatf("vec%0d_count", v), txq.size(), 5);
      end

      txq.delete(); tstart.delete(); expq.delete();
      for (int f = 0; f < 10; f++) begin
         for (int i = 0; i < 6; i++) fr[i] = 8'($urandom_range(0, 255));
         mvm_model(fr, rs);
         for (int i = 0; i < 5; i++) expq.push_back(rs[i]);
         send_frame(fr, 1'b1);
         repeat ($urandom_range(1, 100)) @(negedge clk);
      end
      wait_bytes(50, 4000, "random", ok);
      for (int i = 0; i < 50 && i < txq.size(); i++)
         check($sformatf("rand_f%0d_b%0d", i/5, i%5), txq[i], expq[i]);
      repeat (80) @(negedge clk);
      check("rand_count", txq.size(), 50);

      txq.delete(); tstart.delete();
      send_byte(8'h88); send_byte(8'h88); send_byte(8'hAA);
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send_frame(vecs[0].rx, 1'b0);
      wait_bytes(5, 700, "rst_midframe", ok);
      if (ok)
         for (int i = 0; i < 5; i++)
            check($sformatf("rst_mid_byte%0d", i), txq[i], vecs[0].tx[i]);
      repeat (300) @(negedge clk);
      check("rst_mid_count", txq.size(), 5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
